// File: rtl/opc6_irq_ctrl.sv
// Interrupt controller for the OPC6 CPU: synchronises and latches NSRC requests,
// masks and prioritises them onto int_b[1:0], and exposes an IO-space register file.
module opc6_irq_ctrl #(
    parameter int unsigned NSRC        = 8,
    parameter logic [15:0] BASE_ADDR   = 16'hFE20,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clken,
    input  logic [NSRC-1:0] irq_in,
    input  logic [15:0]     address,
    input  logic [15:0]     cpu_dout,
    input  logic            rnw,
    input  logic            vpa,
    input  logic            vio,
    output logic [15:0]     rd_data,
    output logic            rd_sel,
    output logic [1:0]      int_b
);

    logic [SYNC_STAGES-1:0][NSRC-1:0] sync_q;
    logic [NSRC-1:0] s, s_d, rise;
    logic [NSRC-1:0] pend, ena, prio, mode;
    logic [NSRC-1:0] clr, act, pend_nxt;
    logic [15:0]     vec, vec_nxt, rd_nxt;
    logic [15:0]     pend16, ena16, prio16, mode16;
    logic            hit, wr, rd;
    logic            lvl1_hit, lvl0_hit;
    logic [3:0]      lvl1_idx, lvl0_idx;
    logic            fetch1, fetch0;
    logic            unused_ok;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign act  = pend & ena;

    assign hit = vio && (address[15:4] == BASE_ADDR[15:4]) && (address[3:0] <= 4'd5);
    assign wr  = hit && !rnw;
    assign rd  = hit && rnw;

    assign fetch1 = vpa && rnw && (address == 16'h0004);
    assign fetch0 = vpa && rnw && (address == 16'h0002);

    assign unused_ok = ^cpu_dout;

    always_comb begin
        clr = '0;
        if (wr && address[3:0] == 4'd4)
            clr = cpu_dout[NSRC-1:0];
        // sticky sources: a coincident rise overrides the clear
        pend_nxt = (mode & (rise | (pend & ~clr))) | (~mode & s);
    end

    always_comb begin
        lvl1_hit = 1'b0;
        lvl0_hit = 1'b0;
        lvl1_idx = '0;
        lvl0_idx = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (!lvl1_hit && act[i] && prio[i]) begin
                lvl1_hit = 1'b1;
                lvl1_idx = 4'(i);
            end
            if (!lvl0_hit && act[i] && !prio[i]) begin
                lvl0_hit = 1'b1;
                lvl0_idx = 4'(i);
            end
        end
    end

    always_comb begin
        pend16 = '0;
        ena16  = '0;
        prio16 = '0;
        mode16 = '0;
        pend16[NSRC-1:0] = pend;
        ena16[NSRC-1:0]  = ena;
        prio16[NSRC-1:0] = prio;
        mode16[NSRC-1:0] = mode;
        rd_nxt = '0;
        if (rd) begin
            case (address[3:0])
                4'd0:    rd_nxt = pend16;
                4'd1:    rd_nxt = ena16;
                4'd2:    rd_nxt = prio16;
                4'd3:    rd_nxt = mode16;
                4'd5:    rd_nxt = vec;
                default: rd_nxt = '0;
            endcase
        end
        // a capture on the same edge as a VEC read wins over the read-clear
        vec_nxt = vec;
        if (fetch1)
            vec_nxt = lvl1_hit ? {1'b1, 11'b0, lvl1_idx} : '0;
        else if (fetch0)
            vec_nxt = lvl0_hit ? {1'b0, 11'b0, lvl0_idx} : '0;
        else if (rd && address[3:0] == 4'd5)
            vec_nxt = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            s_d     <= '0;
            pend    <= '0;
            ena     <= '0;
            prio    <= '0;
            mode    <= '0;
            vec     <= '0;
            rd_data <= '0;
            rd_sel  <= 1'b0;
            int_b   <= 2'b11;
        end else if (clken) begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], irq_in};
            s_d     <= s;
            pend    <= pend_nxt;
            vec     <= vec_nxt;
            rd_data <= rd_nxt;
            rd_sel  <= rd;
            int_b   <= {~|(act & prio), ~|(act & ~prio)};
            if (wr) begin
                case (address[3:0])
                    4'd1:    ena  <= cpu_dout[NSRC-1:0];
                    4'd2:    prio <= cpu_dout[NSRC-1:0];
                    4'd3:    mode <= cpu_dout[NSRC-1:0];
                    default: ;
                endcase
            end
        end
    end

endmodule
